smt_fetch_sched: RTL and testbench

Per-cycle fetch scheduler for the SMT front end. It shares the single 4-wide fetch port between NTHREADS hardware threads by round-robin over threads whose instruction queue reports space. It tracks one outstanding fetch per thread and steers each returning bundle to the owning thread queue's write enable. Flushed in-flight bundles are discarded. It sits between the per-thread instruction queues (Space / Write_Enable) and the fetch/icache unit.

---
 rtl/smt_fetch_sched.sv | 154 +++++++++++++++
 tb/tb_smt_fetch_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/smt_fetch_sched.sv
// Fetch scheduler: round-robin share of one fetch port among NTHREADS threads, one fetch in flight per thread.
// Latency: request/tid and write strobe are combinational; thread state and RR pointer update on the grant/response edge.
// Backpressure: request held off by i_Req_Ready=0 (not sticky, tid may change); ineligible threads (busy/no space/disabled) are skipped.
module smt_fetch_sched #(
    parameter int NTHREADS  = 2,
    parameter int TID_WIDTH = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    input  logic [NTHREADS-1:0]  i_Thread_En,
    input  logic [NTHREADS-1:0]  i_Space,
    input  logic [NTHREADS-1:0]  i_Flush,
    output logic                 o_Req_Valid,
    output logic [TID_WIDTH-1:0] o_Req_Tid,
    input  logic                 i_Req_Ready,
    input  logic                 i_Resp_Valid,
    input  logic [TID_WIDTH-1:0] i_Resp_Tid,
    output logic [NTHREADS-1:0]  o_Write_Enable,
    output logic [NTHREADS-1:0]  o_Outstanding,
    output logic                 o_Protocol_Err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [TID_WIDTH:0]   NT_EXT = NTHREADS[TID_WIDTH:0];
    localparam logic [TID_WIDTH-1:0] LAST   = TID_WIDTH'(NTHREADS - 1);

    state_t                r_state [NTHREADS];
    state_t                w_state_nxt [NTHREADS];
    logic [TID_WIDTH-1:0]  r_ptr;
    logic [TID_WIDTH-1:0]  r_last_tid;
    logic                  r_err;

    logic [NTHREADS-1:0]   w_elig;
    logic [NTHREADS-1:0]   w_resp_hit;
    logic [NTHREADS-1:0]   w_grant_vec;
    logic [NTHREADS-1:0]   w_we;
    logic                  w_found;
    logic [TID_WIDTH-1:0]  w_sel;
    logic [TID_WIDTH:0]    w_idx;
    logic                  w_grant;
    logic                  w_resp_in_range;
    logic                  w_resp_idle;
    logic                  w_err_evt;

    assign w_resp_in_range = ({1'b0, i_Resp_Tid} < NT_EXT);

    // Per-thread eligibility and decoded response hit
    always_comb begin
        w_elig     = '0;
        w_resp_hit = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            w_elig[t]     = (r_state[t] == ST_IDLE) & i_Thread_En[t] & i_Space[t];
            w_resp_hit[t] = i_Resp_Valid & w_resp_in_range & (i_Resp_Tid == TID_WIDTH'(t));
        end
    end

    // Round-robin search from the pointer upward, wrapping at NTHREADS-1
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int k = 0; k < NTHREADS; k++) begin
            w_idx = {1'b0, r_ptr} + (TID_WIDTH+1)'(k);
            if (w_idx >= NT_EXT) begin
                w_idx = w_idx - NT_EXT;
            end
            if (!w_found && w_elig[w_idx[TID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[TID_WIDTH-1:0];
            end
        end
    end

    // Nothing is offered while reset is held, even though all threads look idle
    assign o_Req_Valid = w_found & i_Reset_n;
    assign o_Req_Tid   = w_found ? w_sel : r_last_tid;
    assign w_grant     = o_Req_Valid & i_Req_Ready;

    // Thread FSM next state and zero-latency write strobe
    always_comb begin
        w_grant_vec = '0;
        w_we        = '0;
        w_resp_idle = 1'b0;
        for (int t = 0; t < NTHREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            w_grant_vec[t] = w_grant & (w_sel == TID_WIDTH'(t));
            case (r_state[t])
                ST_IDLE: begin
                    // A response here (including one in the grant cycle) is spurious
                    w_resp_idle = w_resp_idle | w_resp_hit[t];
                    if (w_grant_vec[t]) begin
                        // Flush alongside the grant makes the new fetch stale
                        w_state_nxt[t] = i_Flush[t] ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_resp_hit[t]) begin
                        w_state_nxt[t] = ST_IDLE;
                        w_we[t]        = ~i_Flush[t];
                    end else if (i_Flush[t]) begin
                        w_state_nxt[t] = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (w_resp_hit[t]) begin
                        w_state_nxt[t] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[t] = ST_IDLE;
                end
            endcase
        end
    end

    assign w_err_evt      = i_Resp_Valid & (~w_resp_in_range | w_resp_idle);
    assign o_Write_Enable = w_we;
    assign o_Protocol_Err = r_err;

    // Registered-state decode of in-flight fetches
    always_comb begin
        o_Outstanding = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            o_Outstanding[t] = (r_state[t] != ST_IDLE);
        end
    end

    // Thread state, RR pointer, last granted id and sticky error
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_state[t] <= ST_IDLE;
            end
            r_ptr      <= '0;
            r_last_tid <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_state[t] <= w_state_nxt[t];
            end
            if (w_grant) begin
                r_ptr      <= (w_sel == LAST) ? '0 : w_sel + 1'b1;
                r_last_tid <= w_sel;
            end
            r_err <= r_err | w_err_evt;
        end
    end

endmodule

// File: tb/tb_smt_fetch_sched.sv
// Directed bench for smt_fetch_sched, NTHREADS=2 with a 2-bit tid so out-of-range ids are reachable.
module tb_smt_fetch_sched;

    localparam int NT = 2;
    localparam int TW = 2;

    logic          clk;
    logic          rst_n;
    logic [NT-1:0] en;
    logic [NT-1:0] space;
    logic [NT-1:0] flush;
    logic          req_valid;
    logic [TW-1:0] req_tid;
    logic          ready;
    logic          rvld;
    logic [TW-1:0] rtid;
    logic [NT-1:0] we;
    logic [NT-1:0] outst;
    logic          err;

    int total;
    int bad;

    smt_fetch_sched #(.NTHREADS(NT), .TID_WIDTH(TW)) dut (
        .i_Clk          (clk),
        .i_Reset_n      (rst_n),
        .i_Thread_En    (en),
        .i_Space        (space),
        .i_Flush        (flush),
        .o_Req_Valid    (req_valid),
        .o_Req_Tid      (req_tid),
        .i_Req_Ready    (ready),
        .i_Resp_Valid   (rvld),
        .i_Resp_Tid     (rtid),
        .o_Write_Enable (we),
        .o_Outstanding  (outst),
        .o_Protocol_Err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 2'b11;
        space = 2'b11;
        flush = 2'b00;
        ready = 1'b1;
        rvld  = 1'b0;
        rtid  = '0;
        tick();
        tick();
        #1;
        chk("rst_req_valid", 8'(req_valid), 8'h0);
        chk("rst_outst",     8'(outst),     8'h0);
        chk("rst_we",        8'(we),        8'h0);
        chk("rst_err",       8'(err),       8'h0);
        rst_n = 1'b1;

        // cycle 0: grant tid0
        #1;
        chk("c0_valid", 8'(req_valid), 8'h1);
        chk("c0_tid",   8'(req_tid),   8'h0);
        tick();
        // cycle 1: grant tid1
        #1;
        chk("c1_valid", 8'(req_valid), 8'h1);
        chk("c1_tid",   8'(req_tid),   8'h1);
        chk("c1_outst", 8'(outst),     8'h1);
        tick();
        // cycle 2: both in flight
        #1;
        chk("c2_valid", 8'(req_valid), 8'h0);
        chk("c2_outst", 8'(outst),     8'h3);
        tick();
        // cycle 3: response tid1
        ready = 1'b0; rvld = 1'b1; rtid = 2'd1;
        #1;
        chk("c3_we", 8'(we), 8'h2);
        tick();
        // cycle 4: response tid0; tid1 already idle and eligible
        rtid = 2'd0;
        #1;
        chk("c4_we",  8'(we),      8'h1);
        chk("c4_tid", 8'(req_tid), 8'h1);
        tick();
        // cycle 5: all idle, pointer back at 0 -> grant tid0
        rvld = 1'b0; ready = 1'b1;
        #1;
        chk("c5_outst", 8'(outst),     8'h0);
        chk("c5_valid", 8'(req_valid), 8'h1);
        chk("c5_tid",   8'(req_tid),   8'h0);
        tick();
        // cycle 6: flush tid0 while in WAIT
        ready = 1'b0; flush = 2'b01;
        #1;
        chk("c6_outst", 8'(outst), 8'h1);
        chk("c6_we",    8'(we),    8'h0);
        tick();
        flush = 2'b00;
        #1;
        chk("c7_outst", 8'(outst), 8'h1);
        tick();
        // cycle 8: response for dropped fetch is discarded
        rvld = 1'b1; rtid = 2'd0;
        #1;
        chk("c8_we",    8'(we),    8'h0);
        chk("c8_outst", 8'(outst), 8'h1);
        tick();
        rvld = 1'b0;
        #1;
        chk("c9_outst", 8'(outst), 8'h0);
        chk("c9_err",   8'(err),   8'h0);

        // Ready held low three cycles with only tid0 having space
        space = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid", 8'(req_valid), 8'h1);
            chk("hold_tid",   8'(req_tid),   8'h0);
            chk("hold_outst", 8'(outst),     8'h0);
            tick();
        end
        ready = 1'b1;
        #1;
        chk("c12_tid", 8'(req_tid), 8'h0);
        tick();
        // cycle 13: tid0 in WAIT, pointer=1 -> grant tid1
        space = 2'b11;
        #1;
        chk("c13_outst", 8'(outst),   8'h1);
        chk("c13_tid",   8'(req_tid), 8'h1);
        tick();
        // cycle 14: response tid0
        ready = 1'b0; rvld = 1'b1; rtid = 2'd0;
        #1;
        chk("c14_we", 8'(we), 8'h1);
        tick();
        // cycle 15: tid1 flush+response while tid0 is granted
        ready = 1'b1; flush = 2'b10; rtid = 2'd1;
        #1;
        chk("c15_we",    8'(we),        8'h0);
        chk("c15_valid", 8'(req_valid), 8'h1);
        chk("c15_tid",   8'(req_tid),   8'h0);
        tick();
        // cycle 16: tid1 idle, tid0 WAIT, pointer=1; flush with grant to tid1
        rvld = 1'b0;
        #1;
        chk("c16_outst", 8'(outst),   8'h1);
        chk("c16_tid",   8'(req_tid), 8'h1);
        chk("c16_err",   8'(err),     8'h0);
        tick();
        // cycle 17: tid1 went to DROP; its response is discarded
        ready = 1'b0; flush = 2'b00; rvld = 1'b1; rtid = 2'd1;
        #1;
        chk("c17_outst", 8'(outst), 8'h3);
        chk("c17_we",    8'(we),    8'h0);
        tick();
        rtid = 2'd0;
        #1;
        chk("c18_we", 8'(we), 8'h1);
        tick();
        // cycle 19: only tid0 enabled -> grant tid0
        rvld = 1'b0; en = 2'b01; ready = 1'b1;
        #1;
        chk("c19_outst", 8'(outst),   8'h0);
        chk("c19_tid",   8'(req_tid), 8'h0);
        chk("c19_err",   8'(err),     8'h0);
        tick();
        // cycle 20: disable everything; in-flight fetch still written
        en = 2'b00; rvld = 1'b1; rtid = 2'd0;
        #1;
        chk("c20_valid", 8'(req_valid), 8'h0);
        chk("c20_we",    8'(we),        8'h1);
        tick();
        // cycle 21: response to an idle thread
        #1;
        chk("c21_we",  8'(we),  8'h0);
        chk("c21_err", 8'(err), 8'h0);
        tick();
        rtid = 2'd3;
        #1;
        chk("c22_err", 8'(err), 8'h1);
        chk("c22_we",  8'(we),  8'h0);
        tick();
        rvld = 1'b0;
        tick();
        #1;
        chk("err_sticky", 8'(err), 8'h1);

        // Reset clears the error; an out-of-range id alone sets it again
        rst_n = 1'b0;
        #1;
        chk("rst2_err", 8'(err), 8'h0);
        tick();
        rst_n = 1'b1;
        rvld = 1'b1; rtid = 2'd3;
        #1;
        chk("oor_we", 8'(we), 8'h0);
        tick();
        rvld = 1'b0;
        #1;
        chk("oor_err",   8'(err),   8'h1);
        chk("oor_outst", 8'(outst), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
